seq_mul32: RTL and testbench

- Multi-cycle 32x32 integer multiplier implementing the RV32M multiply group: MUL, MULH, MULHSU and MULHU.
- Sits beside the ALU in the execute stage.
- Each cycle it presents a partial-product operand pair to an internal 32-bit ripple-carry adder and registers the adder's sum and carry-out. It is therefore both the operand source and the result consumer of the adder datapath.
- The core stalls on `busy` and captures `result` on `done`.

---
 rtl/seq_mul32.sv | 115 +++++++++++
 tb/tb_seq_mul32.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul32.sv
// Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU): shift-and-add over 32 cycles
// through a 32-bit ripple-carry adder, followed by an optional two's-complement fix-up.
module seq_mul32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   acc_hi_reg, prod_lo_reg, mag_a_reg, result_reg;
    logic [4:0]        count_reg;
    logic              neg_reg;
    logic [1:0]        op_reg;

    logic              a_signed, b_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   add_x, add_y, add_sum, hi_neg;
    logic              add_cin, add_cout;
    logic [XLEN:0]     carry;

    // Sign is only honoured for the operands the selected op treats as signed.
    assign a_signed = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
    assign b_signed = (op == 2'b01) && b[XLEN-1];
    assign mag_a    = a_signed ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
    assign mag_b    = b_signed ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;

    // Shared adder: partial-product accumulate in CALC, low-word increment in FIX.
    always_comb begin
        add_x   = acc_hi_reg;
        add_y   = prod_lo_reg[0] ? mag_a_reg : '0;
        add_cin = 1'b0;
        if (state_reg == FIX) begin
            add_x   = ~prod_lo_reg;
            add_y   = '0;
            add_cin = 1'b1;
        end
    end

    assign carry[0] = add_cin;
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_ripple
            assign add_sum[gi]  = add_x[gi] ^ add_y[gi] ^ carry[gi];
            assign carry[gi+1]  = (add_x[gi] & add_y[gi]) | (add_x[gi] & carry[gi])
                                | (add_y[gi] & carry[gi]);
        end
    endgenerate
    assign add_cout = carry[XLEN];

    // High word of the negated product absorbs the carry out of the low word.
    assign hi_neg = ~acc_hi_reg + {{(XLEN-1){1'b0}}, add_cout};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && !flush) state_next = CALC;
            CALC: begin
                if (flush)                  state_next = IDLE;
                else if (count_reg == 5'd31) state_next = FIX;
            end
            FIX:  state_next = flush ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_hi_reg  <= '0;
            prod_lo_reg <= '0;
            mag_a_reg   <= '0;
            result_reg  <= '0;
            count_reg   <= '0;
            neg_reg     <= 1'b0;
            op_reg      <= 2'b00;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start && !flush) begin
                    op_reg      <= op;
                    mag_a_reg   <= mag_a;
                    prod_lo_reg <= mag_b;
                    acc_hi_reg  <= '0;
                    count_reg   <= '0;
                    neg_reg     <= a_signed ^ b_signed;
                end
                CALC: if (!flush) begin
                    {acc_hi_reg, prod_lo_reg} <= {add_cout, add_sum, prod_lo_reg[XLEN-1:1]};
                    count_reg                 <= count_reg + 5'd1;
                end
                FIX: if (!flush) begin
                    if (op_reg == 2'b00) result_reg <= neg_reg ? add_sum : prod_lo_reg;
                    else                 result_reg <= neg_reg ? hi_neg  : acc_hi_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg == CALC) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_seq_mul32.sv
// Directed and random checks of seq_mul32: latency, op selection, corner values,
// ignored starts, flush and mid-operation reset, using an expected-result queue.
module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res;

    seq_mul32 #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = ((o == 2'b01) || (o == 2'b10)) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // poke_at: cycle index (after E0) at which a stray start is pulsed; -1 for none.
    // start_at_done: raise start in the DONE cycle and leave it high for the next op.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int poke_at, input bit start_at_done,
                          input string tag);
        int n, busy_n;
        logic [31:0] got;
        sb.push_back(exp);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        n = 0; busy_n = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_n++;
            if (n == poke_at) begin
                start = 1'b1; op = 2'b11; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk(32'(done), 32'd1, {tag, ":done"});
        chk(32'(n), 32'd33, {tag, ":latency"});
        chk(32'(busy_n), 32'd33, {tag, ":busy_cycles"});
        chk(32'(busy), 32'd0, {tag, ":busy_at_done"});
        got = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
        chk(result, got, {tag, ":result"});
        last_res = got;
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, x, y, result, got, n);
        if (start_at_done) begin
            start = 1'b1; op = 2'b01; a = 32'h0000_0009; b = 32'h0000_0009;
        end
        tick();
        chk(32'(done), 32'd0, {tag, ":done_drop"});
        chk(result, last_res, {tag, ":result_hold"});
        if (start_at_done) chk(32'(busy), 32'd0, {tag, ":start_in_done_ignored"});
    endtask

    task automatic flush_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input int flush_at, input string tag);
        int pulses;
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < flush_at; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk(32'(busy), 32'd0, {tag, ":busy_after_flush"});
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        chk(32'(pulses), 32'd0, {tag, ":no_done"});
        chk(result, last_res, {tag, ":result_kept"});
        $display("flush op=%0d a=%h b=%h at=%0d result=%h", o, x, y, flush_at, result);
    endtask

    initial begin
        logic [31:0] ops_exp[4];
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          pulses;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        last_res = '0;
        tick(); tick();
        chk(result, 32'h0, "reset:result");
        chk(32'(busy), 32'd0, "reset:busy");
        chk(32'(done), 32'd0, "reset:done");
        rst = 1'b0;
        tick();

        run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, -1, 1'b0, "mul_7x6");

        ops_exp[0] = 32'h0000_0001; ops_exp[1] = 32'h0000_0000;
        ops_exp[2] = 32'hFFFF_FFFF; ops_exp[3] = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++)
            run_op(2'(i), 32'hFFFF_FFFF, 32'hFFFF_FFFF, ops_exp[i], -1, 1'b0, "all_ones");

        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, -1, 1'b0, "mulh_min");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, 1'b0, "mulhsu_min");
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, -1, 1'b0, "mul_pattern");
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000, -1, 1'b0, "mulhsu_zero");

        run_op(2'b00, 32'd100, 32'd25, 32'd2500, 5, 1'b1, "restart_ignored");
        run_op(2'b11, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, -1, 1'b0, "start_after_done");

        flush_op(2'b01, 32'h1111_1111, 32'h2222_2222, 10, "flush_calc");
        run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, -1, 1'b0, "mul_after_flush");

        op = 2'b01; a = 32'hF000_0000; b = 32'h0000_1234; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        chk(result, 32'h0, "midrst:result");
        chk(32'(busy), 32'd0, "midrst:busy");
        chk(32'(done), 32'd0, "midrst:done");
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        chk(32'(pulses), 32'd0, "midrst:no_done");
        rst = 1'b0;
        last_res = 32'h0;
        run_op(2'b00, 32'd11, 32'd13, 32'd143, -1, 1'b0, "after_reset");

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom); ra = $urandom; rb = $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), -1, 1'b0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
